// File: rtl/cuadro_position_ctrl_if.sv
// rtl/cuadro_position_ctrl_if.sv - button/line inputs and square outputs of the position controller
interface cuadro_position_ctrl_if;
  logic [4:0] iBTN;
  logic [9:0] iVcounter;
  logic [7:0] oXRedCounter;
  logic [7:0] oYRedCounter;
  logic [2:0] oColorCuadro;
  logic       oBusy;
  logic       oUpdate;

  modport master (
    output iBTN, iVcounter,
    input  oXRedCounter, oYRedCounter, oColorCuadro, oBusy, oUpdate
  );

  modport slave (
    input  iBTN, iVcounter,
    output oXRedCounter, oYRedCounter, oColorCuadro, oBusy, oUpdate
  );
endinterface

// File: rtl/cuadro_position_ctrl.sv
// rtl/cuadro_position_ctrl.sv - turns button presses/holds into square moves and colour steps
// Commands are latched immediately but only applied during vertical blanking.
module cuadro_position_ctrl #(
  parameter int STEP         = 8,
  parameter int SQUARE       = 16,
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 2_500_000,
  parameter int VIS_TOP      = 142,
  parameter int VIS_BOT      = 398
) (
  input  logic                    Clock,
  input  logic                    Reset,
  cuadro_position_ctrl_if.slave   bus
);

  localparam logic [8:0] MAXPOS = 9'(256 - SQUARE);
  localparam logic [7:0] CENTER = 8'((256 - SQUARE) / 2);

  typedef enum logic [1:0] {IDLE, WAIT_VB, APPLY} state_t;
  typedef enum logic [2:0] {CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_CNTR} cmd_t;

  state_t      r_state, w_next;
  cmd_t        r_cmd, w_cmd;
  logic [4:0]  r_btn_prev;
  logic [23:0] r_hold;
  logic [7:0]  r_x, r_y;
  logic [2:0]  r_col;
  logic        r_busy, r_upd;
  logic        w_hold, w_rep, w_press, w_event, w_blank, w_latch, w_apply;

  function automatic logic [7:0] dec_sat(input logic [7:0] v);
    logic [8:0] w_v;
    w_v = {1'b0, v};
    return (w_v >= 9'(STEP)) ? 8'(w_v - 9'(STEP)) : 8'd0;
  endfunction

  function automatic logic [7:0] inc_sat(input logic [7:0] v);
    logic [8:0] w_s;
    w_s = {1'b0, v} + 9'(STEP);
    return (w_s > MAXPOS) ? 8'(MAXPOS) : 8'(w_s);
  endfunction

  // CNTR alone never auto-repeats; any other held non-zero word does.
  assign w_hold  = (bus.iBTN == r_btn_prev) && (bus.iBTN != 5'd0) && (bus.iBTN != 5'b00001);
  assign w_rep   = w_hold && (r_hold == 24'(REPEAT_DELAY - 1));
  assign w_press = (bus.iBTN != 5'd0) && (bus.iBTN != r_btn_prev);
  assign w_event = w_press || w_rep;
  assign w_blank = (bus.iVcounter < 10'(VIS_TOP)) || (bus.iVcounter >= 10'(VIS_BOT));

  always_comb begin
    w_cmd = CMD_CNTR;
    if (bus.iBTN[4])      w_cmd = CMD_UP;
    else if (bus.iBTN[3]) w_cmd = CMD_DOWN;
    else if (bus.iBTN[2]) w_cmd = CMD_LEFT;
    else if (bus.iBTN[1]) w_cmd = CMD_RIGHT;
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_apply = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_event) begin
          w_next  = WAIT_VB;
          w_latch = 1'b1;
        end
      end
      WAIT_VB: begin
        if (w_blank) w_next = APPLY;
      end
      APPLY: begin
        w_apply = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_btn_prev <= 5'd0;
      r_hold     <= 24'd0;
    end else begin
      r_state    <= w_next;
      r_btn_prev <= bus.iBTN;
      if (!w_hold)    r_hold <= 24'd0;
      else if (w_rep) r_hold <= 24'(REPEAT_DELAY - REPEAT_RATE);
      else            r_hold <= r_hold + 24'd1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cmd  <= CMD_CNTR;
      r_x    <= CENTER;
      r_y    <= CENTER;
      r_col  <= 3'b100;
      r_busy <= 1'b0;
      r_upd  <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_upd  <= w_apply;
      if (w_latch) r_cmd <= w_cmd;
      if (w_apply) begin
        case (r_cmd)
          CMD_UP:    r_y <= dec_sat(r_y);
          CMD_DOWN:  r_y <= inc_sat(r_y);
          CMD_LEFT:  r_x <= dec_sat(r_x);
          CMD_RIGHT: r_x <= inc_sat(r_x);
          default:   r_col <= (r_col == 3'b111) ? 3'b001 : r_col + 3'd1;
        endcase
      end
    end
  end

  assign bus.oXRedCounter = r_x;
  assign bus.oYRedCounter = r_y;
  assign bus.oColorCuadro = r_col;
  assign bus.oBusy        = r_busy;
  assign bus.oUpdate      = r_upd;

endmodule

// File: doc/cuadro_position_ctrl.md
Name: cuadro_position_ctrl

Overview:
- Sequences the square overlay drawn by the VGA controller from the debounced 5-bit button word.
- Converts button presses and holds into move and colour commands.
- Defers every command to vertical blanking so the square never tears.
- Drives the square X/Y position and colour inputs of the VGA controller, and pulses a refresh request for the LCD text path.

Parameters:
- STEP, 8: pixels moved per direction command.
- SQUARE, 16: square edge in pixels; position range is 0..256-SQUARE.
- REPEAT_DELAY, 12_500_000: cycles a direction button is held before the first auto-repeat.
- REPEAT_RATE, 2_500_000: cycles between subsequent auto-repeats.
- VIS_TOP, 142: first visible image line.
- VIS_BOT, 398: first line below the image.

Ports:
- Clock, input, 1: pixel/system clock.
- Reset, input, 1: asynchronous, active-low reset.
- iBTN, input, 5: debounced buttons {UP,DOWN,LEFT,RIGHT,CNTR}, level.
- iVcounter, input, 10: current VGA line.
- oXRedCounter, output, 8: square left X.
- oYRedCounter, output, 8: square top Y.
- oColorCuadro, output, 3: square RGB.
- oBusy, output, 1: high while a command is pending.
- oUpdate, output, 1: one-cycle pulse when new values become visible.

Behaviour:
- Reset (Reset=0, any time, asynchronous):
  - X = Y = (256-SQUARE)/2 = 120; colour = 3'b100.
  - state IDLE; oBusy = 0; oUpdate = 0.
  - hold counter and rBTNPrev cleared; any pending command discarded.
- Event generation:
  - rBTNPrev registers iBTN each cycle.
  - Press event when iBTN != 0 and iBTN != rBTNPrev.
  - Priority when several bits are set: UP > DOWN > LEFT > RIGHT > CNTR; exactly one command per event.
- Auto-repeat (direction buttons only; CNTR never repeats):
  - While iBTN is unchanged, non-zero and not CNTR-only, a 24-bit hold counter increments.
  - At REPEAT_DELAY it issues an event, then reloads to REPEAT_DELAY-REPEAT_RATE so the next event comes REPEAT_RATE cycles later.
  - iBTN change or zero clears the counter.
- FSM:
  - IDLE: on event, latch the 3-bit command, go to WAIT_VB, oBusy = 1.
  - WAIT_VB: further events are dropped. When iVcounter < VIS_TOP or iVcounter >= VIS_BOT, go to APPLY. If already in blank, the transition happens the next cycle.
  - APPLY (exactly one cycle): update registers, go to IDLE. oBusy = 0 and oUpdate = 1 in the following cycle, in which the new outputs are visible.
- Arithmetic, computed in 9 bits, saturating, no wrap:
  - UP: Y = (Y >= STEP) ? Y-STEP : 0.
  - DOWN: Y = min(Y+STEP, 256-SQUARE).
  - LEFT and RIGHT: same rules applied to X.
  - CNTR: colour = colour+1, with 3'b111 going to 3'b001; 3'b000 (frame black) is never produced.
- A move at a bound leaves the value unchanged but still produces the oUpdate pulse.
- Outputs are registered and change only in the APPLY transition or on reset.

Test Plan:
- Reset low for 3 cycles mid-frame, release -> X=120, Y=120, colour=100, oBusy=0, oUpdate=0; a latched pending command is gone.
- iVcounter=200, pulse UP for 1 cycle -> oBusy=1 until iVcounter reaches 398; one cycle later Y=112 and oUpdate=1 for exactly one cycle; X is unchanged.
- Press DOWN 20 times, each pulse applied during blank -> Y saturates at 240; last presses leave Y=240 and still pulse oUpdate.
- Press CNTR 7 times from reset -> colour sequence 101,110,111,001,010,011,100; held CNTR for 3*REPEAT_DELAY -> only one change.
- Bench with REPEAT_DELAY=100, REPEAT_RATE=20; hold RIGHT from X=120 with iVcounter tied to 450 -> events at 1, 101, 121, 141… cycles; X=128, 136, 144, 152…
- iBTN=UP|LEFT together -> only Y decreases. A second press while in WAIT_VB is dropped: exactly one update occurs.
